syn_fifo_ext: RTL and testbench
===============================

# syn_fifo_ext

Parametrised synchronous FIFO, successor to the basic single-clock FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe, and a defined same-cycle read+write rule at both boundaries. It sits between any single-clock producer and consumer pair that needs early back-pressure rather than hard full/empty only.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 16: number of entries; any value ≥ 2; need not be a power of two.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `wdata` in WIDTH: write data, sampled when a write is accepted.
- `rd_en` in 1: read (pop) request.
- `rdata` out WIDTH: read data.
- `rd_valid` out 1: `rdata` holds a popped word.
- `full`, `empty` out 1: count == DEPTH / count == 0.
- `almost_full`, `almost_empty` out 1: threshold flags.
- `overflow`, `underflow` out 1: one-cycle error pulses.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- **Reset** (`rst`=1 at an edge; dominates `wr_en`/`rd_en` in the same cycle):
  - pointers = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0, rdata = 0.
  - Memory contents are not cleared. Reset mid-operation discards all stored words.
- **Write accept:** `wr_en && (!full || rd_accept)`. Data is stored at wr_ptr, and wr_ptr wraps from DEPTH-1 to 0.
- **Read accept:** `rd_en && !empty`. Reads at rd_ptr, which wraps likewise.
- **Full + wr_en + rd_en:** both are accepted; count is unchanged.
- **Empty + wr_en + rd_en:** the write is accepted, the read is rejected (underflow); count becomes 1.
- **Rejected write** (full, no read): data is dropped, state is unchanged, overflow pulses.
- **Rejected read** (empty): state is unchanged, underflow pulses, rd_valid stays 0.
- **Count update:** count_next = count + wr_accept − rd_accept. It never exceeds DEPTH and never goes below 0.
- **Flag timing:** all flags are registered, derived from count_next, and reflect the state after the edge.

## Timing
- **Write-to-empty deassert:** a write accepted at edge N deasserts `empty` at N.
- **Read latency (default):** a read accepted at edge N presents its word on `rdata` with `rd_valid`=1 in the cycle after N. Both are held for one cycle; `rdata` then holds its value while `rd_valid` = 0.
- **Error pulses:** `overflow` and `underflow` are high for exactly the one cycle following the offending edge. Back-to-back rejects keep them high.
- **Throughput:** one write and one read per cycle, sustained.

## Configuration
- **`SYN_FIFO_FWFT_EN` defined:** first-word-fall-through mode.
  - `rdata` continuously shows mem[rd_ptr].
  - `rd_valid` = !empty.
  - `rd_en` acts as an acknowledge that pops the current word.
  - Read latency is 0; a written word is visible on `rdata` in the cycle after its write edge.
- **Not defined:** registered-read behaviour as described under Timing.
- Acceptance, count, flag and error rules are identical in both modes.

## Structure
- **Package `syn_fifo_ext_pkg`:**
  - default WIDTH/DEPTH constants;
  - a count-width function (clog2 of DEPTH+1);
  - a pointer-width function (clog2 of DEPTH, minimum 1).
- **Sub-module `syn_fifo_mem`:** one write port and one read port, synchronous write, storage array only.
- **Top level:** pointers, count, flags and error logic.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF=14, AE=2.
1. Reset, then 16 writes of 0x01..0x10:
   - almost_empty drops after write 3; almost_full rises after write 14; full = 1 and count = 16 after write 16.
2. From full, a 17th write of 0x55:
   - overflow high for one cycle; count stays 16.
   - 16 reads then return 0x01..0x10 in order (no 0x55); empty = 1 and underflow = 0.
3. Read from empty after reset:
   - underflow = 1 for one cycle, rd_valid = 0, count = 0.
4. Full plus simultaneous wr_en (0xAA) and rd_en:
   - both accepted; count stays 16; read returns 0x01; 0xAA is the last word read out.
5. Empty plus simultaneous wr_en (0x3C) and rd_en:
   - underflow pulse; count = 1.
   - Next read returns 0x3C (one cycle later without FWFT; FWFT shows 0x3C on rdata immediately with rd_valid = 1).
6. `rst` asserted with count = 5 and wr_en = 1:
   - next cycle count = 0, empty = 1, overflow/underflow = 0; a following read flags underflow.

Source files
------------

// File: rtl/syn_fifo_ext_pkg.sv
// Shared constants and width helpers for the syn_fifo_ext FIFO.
package syn_fifo_ext_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A depth-2 FIFO still needs one pointer bit, hence the floor of 1.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/syn_fifo_ext_if.sv
// Producer/consumer bundle for syn_fifo_ext; master drives requests, slave is the FIFO.
interface syn_fifo_ext_if
   import syn_fifo_ext_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   logic                      wr_en;
   logic [WIDTH-1:0]          wdata;
   logic                      rd_en;
   logic [WIDTH-1:0]          rdata;
   logic                      rd_valid;
   logic                      full;
   logic                      empty;
   logic                      almost_full;
   logic                      almost_empty;
   logic                      overflow;
   logic                      underflow;
   logic [cnt_w(DEPTH)-1:0]   count;

   modport master (
      output wr_en, wdata, rd_en,
      input  rdata, rd_valid, full, empty, almost_full, almost_empty,
             overflow, underflow, count
   );

   modport slave (
      input  wr_en, wdata, rd_en,
      output rdata, rd_valid, full, empty, almost_full, almost_empty,
             overflow, underflow, count
   );
endinterface

// File: rtl/syn_fifo_ext_mem.sv
// Storage array for syn_fifo_ext: synchronous write port, combinational read port.
module syn_fifo_mem
   import syn_fifo_ext_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PW    = ptr_w(DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // No reset: contents survive rst, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/syn_fifo_ext.sv
// Synchronous FIFO with occupancy count, threshold flags and error pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module syn_fifo_ext
   import syn_fifo_ext_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic           clk,
   input  logic           rst,
   syn_fifo_ext_if.slave  bus
);
   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             af_q, af_d, ae_q, ae_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] mem_rdata;

   syn_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.wdata),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // A pop frees the slot the same edge, so a write into a full FIFO is legal alongside it.
   always_comb begin
      rd_acc   = bus.rd_en && !empty_q;
      wr_acc   = bus.wr_en && (!full_q || rd_acc);
      wr_ptr_d = wr_acc ? ((wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? ((rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      af_d     = (count_d >= AF_C);
      ae_d     = (count_d <= AE_C);
      ovf_d    = bus.wr_en && !wr_acc;
      udf_d    = bus.rd_en && !rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef SYN_FIFO_FWFT_EN
   assign bus.rdata    = mem_rdata;
   assign bus.rd_valid = !empty_q;
`else
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rd_valid_q, rd_valid_d;

   // rdata holds the last popped word; only rd_valid drops back.
   always_comb begin
      rdata_d    = rd_acc ? mem_rdata : rdata_q;
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_syn_fifo_ext.sv
// Directed bench for syn_fifo_ext in registered-read mode (WIDTH=8, DEPTH=16, AF=14, AE=2).
module tb_syn_fifo_ext;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   syn_fifo_ext_if #(.WIDTH(8), .DEPTH(16)) bus ();

   syn_fifo_ext #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock with the given requests; outputs are sampled 1ns after the edge.
   task automatic step(input logic w, input logic [7:0] wd, input logic r);
      bus.wr_en = w;
      bus.wdata = wd;
      bus.rd_en = r;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.wdata = '0;
      do_reset();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_ae", 32'(bus.almost_empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_af", 32'(bus.almost_full), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_udf", 32'(bus.underflow), 0);
      chk("rst_rdv", 32'(bus.rd_valid), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);

      // Read from empty
      step(1'b0, 8'h00, 1'b1);
      chk("t3_udf", 32'(bus.underflow), 1);
      chk("t3_rdv", 32'(bus.rd_valid), 0);
      chk("t3_count", 32'(bus.count), 0);
      step(1'b0, 8'h00, 1'b0);
      chk("t3_udf_drop", 32'(bus.underflow), 0);

      // Fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b0);
         chk("t1_count", 32'(bus.count), 32'(i));
         chk("t1_ae", 32'(bus.almost_empty), (i <= 2) ? 1 : 0);
         chk("t1_af", 32'(bus.almost_full), (i >= 14) ? 1 : 0);
         chk("t1_full", 32'(bus.full), (i == 16) ? 1 : 0);
         chk("t1_empty", 32'(bus.empty), 0);
      end

      // Write into full
      step(1'b1, 8'h55, 1'b0);
      chk("t2_ovf", 32'(bus.overflow), 1);
      chk("t2_count", 32'(bus.count), 16);
      step(1'b0, 8'h00, 1'b0);
      chk("t2_ovf_drop", 32'(bus.overflow), 0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("t2_rdata", 32'(bus.rdata), 32'(i));
         chk("t2_rdv", 32'(bus.rd_valid), 1);
      end
      chk("t2_empty", 32'(bus.empty), 1);
      chk("t2_udf", 32'(bus.underflow), 0);
      chk("t2_count0", 32'(bus.count), 0);
      step(1'b0, 8'h00, 1'b0);
      chk("t2_rdv_drop", 32'(bus.rd_valid), 0);
      chk("t2_rdata_hold", 32'(bus.rdata), 32'h10);

      // Full with simultaneous write and read
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hAA, 1'b1);
      chk("t4_count", 32'(bus.count), 16);
      chk("t4_full", 32'(bus.full), 1);
      chk("t4_ovf", 32'(bus.overflow), 0);
      chk("t4_rdata", 32'(bus.rdata), 32'h01);
      chk("t4_rdv", 32'(bus.rd_valid), 1);
      for (int i = 2; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("t4_drain", 32'(bus.rdata), 32'(i));
      end
      step(1'b0, 8'h00, 1'b1);
      chk("t4_last", 32'(bus.rdata), 32'hAA);
      chk("t4_count0", 32'(bus.count), 0);

      // Empty with simultaneous write and read
      step(1'b1, 8'h3C, 1'b1);
      chk("t5_udf", 32'(bus.underflow), 1);
      chk("t5_count", 32'(bus.count), 1);
      chk("t5_rdv", 32'(bus.rd_valid), 0);
      chk("t5_empty", 32'(bus.empty), 0);
      step(1'b0, 8'h00, 1'b1);
      chk("t5_rdata", 32'(bus.rdata), 32'h3C);
      chk("t5_rdv2", 32'(bus.rd_valid), 1);
      chk("t5_udf_drop", 32'(bus.underflow), 0);
      chk("t5_count0", 32'(bus.count), 0);

      // Reset mid-operation dominates a write
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
      chk("t6_count5", 32'(bus.count), 5);
      rst = 1'b1;
      step(1'b1, 8'h77, 1'b0);
      rst = 1'b0;
      chk("t6_count", 32'(bus.count), 0);
      chk("t6_empty", 32'(bus.empty), 1);
      chk("t6_ovf", 32'(bus.overflow), 0);
      chk("t6_udf", 32'(bus.underflow), 0);
      chk("t6_rdv", 32'(bus.rd_valid), 0);
      step(1'b0, 8'h00, 1'b1);
      chk("t6_udf_after", 32'(bus.underflow), 1);
      chk("t6_count_after", 32'(bus.count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
